life_cell_locator: RTL and testbench
====================================

// Module: life_cell_locator
// PURPOSE
//   Divider-free pixel-to-cell mapper. Sits between vga_sync and the board colour stage.
//   Consumes the hpos/vpos raster position and tracks the current board cell with incremental counters.
//   Produces, one cycle later, the cell address, the in-board flag and the sub-cell offsets.
//   Replaces the per-pixel "/ CELL_SIZE" arithmetic on the render path.
// PARAMETERS
//   BIT_WIDTH   3    log2 board columns (BOARD_WIDTH = 2**BIT_WIDTH)
//   BIT_HEIGHT  3    log2 board rows (BOARD_HEIGHT = 2**BIT_HEIGHT)
//   CELL_SIZE   50   cell edge length in pixels
//   H_ACTIVE    640  visible pixels per line
//   V_ACTIVE    480  visible lines
//   H_TOTAL     800  pixels per line, including blanking; hpos wraps at H_TOTAL-1
//   V_TOTAL     525  lines per frame; vpos wraps at V_TOTAL-1
//   Derived: X0 = (H_ACTIVE - CELL_SIZE*BOARD_WIDTH)/2 = 120; Y0 = (V_ACTIVE - CELL_SIZE*BOARD_HEIGHT)/2 = 40
// PORTS
//   clk          in   1     pixel clock
//   reset        in   1     synchronous, active-high reset
//   hpos         in   10    horizontal position from vga_sync
//   vpos         in   10    vertical position from vga_sync
//   in_board     out  1     the previous-cycle pixel lies inside the board rectangle
//   visible      out  1     the previous-cycle pixel lies inside the H_ACTIVE x V_ACTIVE area
//   cell_addr    out  BW+BH row*BOARD_WIDTH + col; 0 when in_board = 0
//   sub_x        out  6     pixel offset inside the cell, 0..CELL_SIZE-1
//   sub_y        out  6     line offset inside the cell, 0..CELL_SIZE-1
//   cell_edge    out  1     in_board and (sub_x or sub_y equals 0 or CELL_SIZE-1)
//   frame_start  out  1     1-cycle pulse for hpos=0, vpos=0
//   resync       out  1     1-cycle pulse when a raster discontinuity is detected
// BEHAVIOUR
//   - Latency: exactly 1 clk. Every output at cycle t+1 describes hpos/vpos sampled at t.
//     The colour stage delays hsync/vsync by 1 to align.
//   - Reset: all outputs 0; internal col/row/sub counters 0; tracker state = UNLOCKED.
//   - Horizontal:
//       hpos == X0: col = 0, sub_x = 0.
//       Otherwise, while in the board: sub_x increments; at CELL_SIZE-1 it wraps to 0 and col++.
//       Leaves the board at hpos == X0 + CELL_SIZE*BOARD_WIDTH (520).
//   - Vertical: evaluated once per line, when hpos == 0.
//       vpos == Y0: row = 0, sub_y = 0.
//       Otherwise, inside the board: sub_y increments; at CELL_SIZE-1 it wraps to 0 and row++.
//       Out of the board at vpos == 440.
//   - Outputs must equal (hpos-X0)/CELL_SIZE, (hpos-X0)%CELL_SIZE (and likewise for vpos) for every in-board pixel.
//   - Tracker FSM:
//       UNLOCKED -> LOCKED on the first hpos==0 && vpos==0 seen.
//       LOCKED -> UNLOCKED when hpos != prev_hpos+1 (modulo H_TOTAL),
//         or when vpos changes other than at the hpos wrap (+1 modulo V_TOTAL).
//       resync pulses on that transition.
//       While UNLOCKED: in_board = 0, cell_edge = 0, cell_addr = 0. visible and frame_start still track the inputs.
//   - Counter widths: col is BW bits, row is BH bits, sub is 6 bits; no overflow past BOARD_WIDTH-1 or BOARD_HEIGHT-1.
//   - Reset asserted mid-frame: the outputs clear the next cycle, and the block relocks on the next frame origin.
// STRUCTURE
//   - Shared package life_pkg: BIT_WIDTH, BIT_HEIGHT, CELL_SIZE, the timing totals, X0/Y0,
//     and the cell_addr_t typedef (BW+BH bits). The Life engine and the colour stage use the same package.
//   - Sub-module life_axis_counter, instantiated twice (horizontal and vertical).
//     Ports: load, step, en -> idx, sub, active.
//   - Top level holds the FSM, the continuity check and the output register stage.
// TESTING
//   1. Reset, then two clean frames
//      -> first frame_start relocks.
//      -> In frame 2, hpos=120, vpos=40 gives cell_addr=0, sub_x=0, sub_y=0, in_board=1, cell_edge=1.
//   2. hpos=169/170 and hpos=519/520 at vpos=300
//      -> 169/170: col 0, sub 49, then col 1, sub 0.
//      -> vpos=300 is row 5, so addr=47 at hpos=519, then in_board=0 at 520.
//   3. vpos=439 / vpos=440 at hpos=519
//      -> vpos=439 gives cell_addr=63, sub_y=49, in_board=1; vpos=440 gives in_board=0.
//   4. Full-frame scoreboard: compare every pixel against a division-based model -> zero mismatches.
//      Check that in_board is high for exactly 160000 pixels per frame.
//   5. Inject hpos jump 300 -> 305 mid-line
//      -> resync pulses once; in_board = 0 until the next frame origin; then outputs match the model.
//   6. Assert reset at hpos=250, vpos=200 for 1 cycle
//      -> all outputs 0 the next cycle.
//      -> No in_board until frame_start; correct mapping afterwards.

Source files
------------

// File: rtl/life_pkg.sv
// Shared board geometry and VGA timing for the Life engine, the cell locator and the colour stage.
package life_pkg;

    localparam int BIT_WIDTH    = 3;
    localparam int BIT_HEIGHT   = 3;
    localparam int BOARD_WIDTH  = 2 ** BIT_WIDTH;
    localparam int BOARD_HEIGHT = 2 ** BIT_HEIGHT;
    localparam int CELL_SIZE    = 50;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    localparam int X0 = (H_ACTIVE - CELL_SIZE * BOARD_WIDTH) / 2;
    localparam int Y0 = (V_ACTIVE - CELL_SIZE * BOARD_HEIGHT) / 2;

    localparam int POS_W = 10;
    localparam int SUB_W = 6;

    typedef logic [BIT_WIDTH+BIT_HEIGHT-1:0] cell_addr_t;

    typedef enum logic {
        TRK_UNLOCKED = 1'b0,
        TRK_LOCKED   = 1'b1
    } trk_state_t;

    // Next raster coordinate, wrapping at total-1.
    function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] pos, input int total);
        if (int'(pos) == total - 1)
            return '0;
        else
            return pos + 1'b1;
    endfunction

endpackage

// File: rtl/life_axis_counter.sv
// Incremental cell/sub-cell tracker for one raster axis; outputs describe the position presented this cycle.
module life_axis_counter
    import life_pkg::*;
#(
    parameter int IDX_W     = 3,
    parameter int COUNT     = 8,
    parameter int CELL_SIZE = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic [SUB_W-1:0] sub,
    output logic             active
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);

    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [SUB_W-1:0] sub_reg, sub_next;
    logic             active_reg, active_next;

    always_comb begin
        idx_next    = idx_reg;
        sub_next    = sub_reg;
        active_next = active_reg;
        if (en) begin
            if (load) begin
                idx_next    = '0;
                sub_next    = '0;
                active_next = 1'b1;
            end else if (step) begin
                active_next = 1'b1;
                if (sub_reg == SUB_LAST) begin
                    sub_next = '0;
                    // Saturate so a missed band end can never alias to column/row 0.
                    if (idx_reg != IDX_LAST)
                        idx_next = idx_reg + 1'b1;
                end else begin
                    sub_next = sub_reg + 1'b1;
                end
            end else begin
                idx_next    = '0;
                sub_next    = '0;
                active_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg    <= '0;
            sub_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            idx_reg    <= idx_next;
            sub_reg    <= sub_next;
            active_reg <= active_next;
        end
    end

    assign idx    = idx_next;
    assign sub    = sub_next;
    assign active = active_next;

endmodule

// File: rtl/life_cell_locator.sv
// Divider-free raster-to-cell mapper with raster continuity tracking; all outputs lag hpos/vpos by one clock.
module life_cell_locator
    import life_pkg::*;
#(
    parameter int CELL_SIZE = life_pkg::CELL_SIZE,
    parameter int H_ACTIVE  = life_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = life_pkg::V_ACTIVE,
    parameter int H_TOTAL   = life_pkg::H_TOTAL,
    parameter int V_TOTAL   = life_pkg::V_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    output logic             in_board,
    output logic             visible,
    output cell_addr_t       cell_addr,
    output logic [SUB_W-1:0] sub_x,
    output logic [SUB_W-1:0] sub_y,
    output logic             cell_edge,
    output logic             frame_start,
    output logic             resync
);

    localparam int X_START = (H_ACTIVE - CELL_SIZE * BOARD_WIDTH) / 2;
    localparam int Y_START = (V_ACTIVE - CELL_SIZE * BOARD_HEIGHT) / 2;
    localparam int X_END   = X_START + CELL_SIZE * BOARD_WIDTH;
    localparam int Y_END   = Y_START + CELL_SIZE * BOARD_HEIGHT;

    localparam logic [POS_W-1:0] X_START_P  = POS_W'(X_START);
    localparam logic [POS_W-1:0] Y_START_P  = POS_W'(Y_START);
    localparam logic [POS_W-1:0] X_END_P    = POS_W'(X_END);
    localparam logic [POS_W-1:0] Y_END_P    = POS_W'(Y_END);
    localparam logic [POS_W-1:0] H_ACTIVE_P = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACTIVE_P = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] H_LAST_P   = POS_W'(H_TOTAL - 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CELL_SIZE - 1);

    trk_state_t             state_reg;
    logic [POS_W-1:0]       prev_h_reg, prev_v_reg;
    logic                   in_board_reg, visible_reg, cell_edge_reg;
    logic                   frame_start_reg, resync_reg;
    cell_addr_t             cell_addr_reg;
    logic [SUB_W-1:0]       sub_x_reg, sub_y_reg;

    logic [BIT_WIDTH-1:0]   h_idx;
    logic [BIT_HEIGHT-1:0]  v_idx;
    logic [SUB_W-1:0]       h_sub, v_sub;
    logic                   h_active, v_active;

    logic [POS_W-1:0]       exp_h, exp_v;
    logic                   origin, discont, locked_now, in_board_next, cell_edge_next;

    life_axis_counter #(
        .IDX_W(BIT_WIDTH), .COUNT(BOARD_WIDTH), .CELL_SIZE(CELL_SIZE)
    ) u_h_axis (
        .clk(clk), .reset(reset),
        .en(1'b1),
        .load(hpos == X_START_P),
        .step((hpos > X_START_P) && (hpos < X_END_P)),
        .idx(h_idx), .sub(h_sub), .active(h_active)
    );

    // The vertical axis only advances at the start of each line.
    life_axis_counter #(
        .IDX_W(BIT_HEIGHT), .COUNT(BOARD_HEIGHT), .CELL_SIZE(CELL_SIZE)
    ) u_v_axis (
        .clk(clk), .reset(reset),
        .en(hpos == '0),
        .load(vpos == Y_START_P),
        .step((vpos > Y_START_P) && (vpos < Y_END_P)),
        .idx(v_idx), .sub(v_sub), .active(v_active)
    );

    always_comb begin
        origin = (hpos == '0) && (vpos == '0);
        exp_h  = wrap_inc(prev_h_reg, H_TOTAL);
        exp_v  = (prev_h_reg == H_LAST_P) ? wrap_inc(prev_v_reg, V_TOTAL) : prev_v_reg;
        discont = (hpos != exp_h) || (vpos != exp_v);
        // The pixel that triggers a lock or an unlock is already judged by the new state.
        locked_now = (state_reg == TRK_LOCKED) ? !discont : origin;
        in_board_next  = locked_now && h_active && v_active;
        cell_edge_next = in_board_next &&
                         ((h_sub == '0) || (h_sub == SUB_LAST) ||
                          (v_sub == '0) || (v_sub == SUB_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= TRK_UNLOCKED;
            prev_h_reg      <= '0;
            prev_v_reg      <= '0;
            in_board_reg    <= 1'b0;
            visible_reg     <= 1'b0;
            cell_edge_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            resync_reg      <= 1'b0;
            cell_addr_reg   <= '0;
            sub_x_reg       <= '0;
            sub_y_reg       <= '0;
        end else begin
            prev_h_reg      <= hpos;
            prev_v_reg      <= vpos;
            visible_reg     <= (hpos < H_ACTIVE_P) && (vpos < V_ACTIVE_P);
            frame_start_reg <= origin;
            in_board_reg    <= in_board_next;
            cell_edge_reg   <= cell_edge_next;
            cell_addr_reg   <= in_board_next ? cell_addr_t'({v_idx, h_idx}) : '0;
            sub_x_reg       <= in_board_next ? h_sub : '0;
            sub_y_reg       <= in_board_next ? v_sub : '0;
            resync_reg      <= 1'b0;
            case (state_reg)
                TRK_UNLOCKED: begin
                    if (origin)
                        state_reg <= TRK_LOCKED;
                end
                TRK_LOCKED: begin
                    if (discont) begin
                        state_reg  <= TRK_UNLOCKED;
                        resync_reg <= 1'b1;
                    end
                end
                default: state_reg <= TRK_UNLOCKED;
            endcase
        end
    end

    assign in_board    = in_board_reg;
    assign visible     = visible_reg;
    assign cell_addr   = cell_addr_reg;
    assign sub_x       = sub_x_reg;
    assign sub_y       = sub_y_reg;
    assign cell_edge   = cell_edge_reg;
    assign frame_start = frame_start_reg;
    assign resync      = resync_reg;

endmodule

// File: tb/tb_life_cell_locator.sv
// Scoreboard bench for life_cell_locator on a reduced raster (6-pixel cells, 72x60 total) to keep frames short.
module tb_life_cell_locator;

    localparam int CS = 6;
    localparam int HA = 64;
    localparam int VA = 56;
    localparam int HT = 72;
    localparam int VT = 60;
    localparam int X0 = 8;
    localparam int Y0 = 4;
    localparam int XE = 56;
    localparam int YE = 52;
    localparam int BOARD_PIX = 48 * 48;

    typedef struct packed {
        logic       ib;
        logic       vis;
        logic [5:0] addr;
        logic [5:0] sx;
        logic [5:0] sy;
        logic       ce;
        logic       fs;
        logic       rs;
    } exp_t;

    typedef struct {
        exp_t  model;
        logic  hand_on;
        exp_t  hand;
        string name;
        logic  cnt_chk;
        int    h;
        int    v;
    } item_t;

    typedef struct {
        int    frame;
        int    h;
        int    v;
        string name;
        exp_t  e;
    } hand_t;

    logic       clk;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       in_board, visible, cell_edge, frame_start, resync;
    logic [5:0] cell_addr, sub_x, sub_y;

    item_t q[$];
    hand_t hand_tab[$];
    int    n_checks;
    int    n_fail;
    int    frame_id;
    bit    model_locked;

    life_cell_locator #(
        .CELL_SIZE(CS), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .in_board(in_board), .visible(visible), .cell_addr(cell_addr),
        .sub_x(sub_x), .sub_y(sub_y), .cell_edge(cell_edge),
        .frame_start(frame_start), .resync(resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(int ib, int vis, int addr, int sx, int sy, int ce, int fs, int rs);
        exp_t e;
        e.ib = 1'(ib); e.vis = 1'(vis); e.addr = 6'(addr);
        e.sx = 6'(sx); e.sy = 6'(sy); e.ce = 1'(ce); e.fs = 1'(fs); e.rs = 1'(rs);
        return e;
    endfunction

    function automatic exp_t model(int h, int v, bit locked, bit rs);
        exp_t e;
        int sx, sy;
        e = '0;
        e.vis = (h < HA) && (v < VA);
        e.fs  = (h == 0) && (v == 0);
        e.rs  = rs;
        if (locked && h >= X0 && h < XE && v >= Y0 && v < YE) begin
            sx     = (h - X0) % CS;
            sy     = (v - Y0) % CS;
            e.ib   = 1'b1;
            e.addr = 6'(((v - Y0) / CS) * 8 + (h - X0) / CS);
            e.sx   = 6'(sx);
            e.sy   = 6'(sy);
            e.ce   = (sx == 0) || (sx == CS - 1) || (sy == 0) || (sy == CS - 1);
        end
        return e;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("ib=%0d vis=%0d addr=%0d sx=%0d sy=%0d edge=%0d fs=%0d rs=%0d",
                         e.ib, e.vis, e.addr, e.sx, e.sy, e.ce, e.fs, e.rs);
    endfunction

    task automatic add_hand(int fr, int h, int v, string name, exp_t e);
        hand_t t;
        t.frame = fr; t.h = h; t.v = v; t.name = name; t.e = e;
        hand_tab.push_back(t);
    endtask

    task automatic drive(int h, int v, bit rst, bit jump, bit cnt_chk);
        item_t it;
        bit    rs;
        @(negedge clk);
        reset = rst;
        hpos  = 10'(h);
        vpos  = 10'(v);
        rs    = 1'b0;
        if (rst) begin
            model_locked = 1'b0;
            it.model     = '0;
        end else begin
            if (jump) begin
                rs           = model_locked;
                model_locked = 1'b0;
            end
            if (h == 0 && v == 0)
                model_locked = 1'b1;
            it.model = model(h, v, model_locked, rs);
        end
        it.hand_on = 1'b0;
        it.hand    = '0;
        it.name    = "";
        foreach (hand_tab[i]) begin
            if (hand_tab[i].frame == frame_id && hand_tab[i].h == h && hand_tab[i].v == v) begin
                it.hand_on = 1'b1;
                it.hand    = hand_tab[i].e;
                it.name    = hand_tab[i].name;
            end
        end
        it.cnt_chk = cnt_chk;
        it.h       = h;
        it.v       = v;
        q.push_back(it);
    endtask

    // One raster frame; jump_v/jump_from/jump_to inject a horizontal skip, rst_h/rst_v a 1-cycle reset.
    task automatic run_frame(int fid, int jump_v, int jump_from, int jump_to,
                             int rst_h, int rst_v, bit cnt_chk);
        int h;
        bit j, r;
        frame_id = fid;
        for (int v = 0; v < VT; v++) begin
            h = 0;
            while (h < HT) begin
                j = 1'b0;
                if (v == jump_v && h == jump_from + 1) begin
                    h = jump_to;
                    j = 1'b1;
                end
                r = (h == rst_h) && (v == rst_v);
                drive(h, v, r, j, cnt_chk && (h == HT - 1) && (v == VT - 1));
                h++;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents the mapping of the previous input.
    initial begin
        item_t it;
        exp_t  act;
        int    ib_cnt;
        ib_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                act.ib = in_board; act.vis = visible; act.addr = cell_addr;
                act.sx = sub_x; act.sy = sub_y; act.ce = cell_edge;
                act.fs = frame_start; act.rs = resync;
                n_checks++;
                if (act !== it.model) begin
                    n_fail++;
                    $display("FAIL pixel(%0d,%0d) got %s required %s", it.h, it.v, fmt(act), fmt(it.model));
                end
                if (it.hand_on) begin
                    n_checks++;
                    if (act !== it.hand) begin
                        n_fail++;
                        $display("FAIL %s got %s required %s", it.name, fmt(act), fmt(it.hand));
                    end else begin
                        $display("check %s ok: %s", it.name, fmt(act));
                    end
                end
                if (act.fs === 1'b1)
                    ib_cnt = 0;
                if (act.ib === 1'b1)
                    ib_cnt++;
                if (it.cnt_chk) begin
                    n_checks++;
                    if (ib_cnt != BOARD_PIX) begin
                        n_fail++;
                        $display("FAIL board_pixel_count got %0d required %0d", ib_cnt, BOARD_PIX);
                    end else begin
                        $display("check board_pixel_count ok: %0d", ib_cnt);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        frame_id = 0;
        model_locked = 1'b0;
        reset = 1'b1;
        hpos  = '0;
        vpos  = '0;

        add_hand(2,  0,  0, "frame_origin",      mk(0, 1,  0, 0, 0, 0, 1, 0));
        add_hand(2,  8,  4, "board_origin",      mk(1, 1,  0, 0, 0, 1, 0, 0));
        add_hand(2, 18, 12, "cell_interior",     mk(1, 1,  9, 4, 2, 0, 0, 0));
        add_hand(2, 13, 36, "col0_last_sub",     mk(1, 1, 40, 5, 2, 1, 0, 0));
        add_hand(2, 14, 36, "col1_first_sub",    mk(1, 1, 41, 0, 2, 1, 0, 0));
        add_hand(2, 55, 36, "last_col_row5",     mk(1, 1, 47, 5, 2, 1, 0, 0));
        add_hand(2, 56, 36, "right_board_exit",  mk(0, 1,  0, 0, 0, 0, 0, 0));
        add_hand(2, 55, 51, "last_cell",         mk(1, 1, 63, 5, 5, 1, 0, 0));
        add_hand(2, 55, 52, "bottom_board_exit", mk(0, 1,  0, 0, 0, 0, 0, 0));
        add_hand(3, 35, 20, "jump_resync",       mk(0, 1,  0, 0, 0, 0, 0, 1));
        add_hand(3, 40, 30, "unlocked_in_board", mk(0, 1,  0, 0, 0, 0, 0, 0));
        add_hand(4,  8,  4, "relock_origin",     mk(1, 1,  0, 0, 0, 1, 0, 0));
        add_hand(5, 30, 25, "reset_clears",      mk(0, 0,  0, 0, 0, 0, 0, 0));
        add_hand(5, 31, 25, "after_reset",       mk(0, 1,  0, 0, 0, 0, 0, 0));
        add_hand(6, 21, 23, "after_reset_relock",mk(1, 1, 26, 1, 1, 0, 0, 0));

        repeat (3) drive(0, 0, 1'b1, 1'b0, 1'b0);
        run_frame(1, -1, -1, -1, -1, -1, 1'b1);
        run_frame(2, -1, -1, -1, -1, -1, 1'b1);
        run_frame(3, 20, 30, 35, -1, -1, 1'b0);
        run_frame(4, -1, -1, -1, -1, -1, 1'b1);
        run_frame(5, -1, -1, -1, 30, 25, 1'b0);
        run_frame(6, -1, -1, -1, -1, -1, 1'b1);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout got %0d pending required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
